// File: rtl/sevenseg_pkg.sv
// -----------------------------------------------------------------------------
// sevenseg_pkg
//   Shared definitions for the 7-segment scan driver:
//   - SEG_A..SEG_G / SEG_DP : bit positions inside the 8-bit {dp,g,f,e,d,c,b,a}
//     segment bus
//   - SEG_OFF               : all segments dark (before polarity inversion)
//   - hex_to_seg()          : hex nibble -> 7 segment pattern {g,f,e,d,c,b,a},
//     active-high
// -----------------------------------------------------------------------------
package sevenseg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] SEG_OFF = 8'h00;

    // Lower-case b and d keep the glyphs distinct from 8 and 0.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            4'hF:    pat = 7'h71;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/sevenseg_lzb_mask.sv
// -----------------------------------------------------------------------------
// sevenseg_lzb_mask
//   Combinational leading-zero detector. Bit i of lz_mask_o is set when
//   nibble i and every higher nibble of value_i are zero. Digit 0 is never
//   flagged, so a value of zero still shows a single "0".
// Ports:
//   value_i    in   4*NUM_DIGITS  hex nibbles, digit 0 in the LSBs
//   lz_mask_o  out  NUM_DIGITS    1 = digit is a leading zero
// -----------------------------------------------------------------------------
module sevenseg_lzb_mask #(
    parameter int NUM_DIGITS = 4
) (
    input  logic [4*NUM_DIGITS-1:0] value_i,
    output logic [NUM_DIGITS-1:0]   lz_mask_o
);

    logic zero_run_s;

    // Walk from the most significant digit down, keeping a running "all zero so far".
    always_comb begin
        lz_mask_o  = '0;
        zero_run_s = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run_s   = zero_run_s & (value_i[4*i +: 4] == 4'h0);
            lz_mask_o[i] = zero_run_s;
        end
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_driver
//   Time-multiplexed N-digit 7-segment driver. A load strobe captures a new
//   value into a pending buffer; the pending buffer is copied into the
//   displayed shadow only when the scan wraps back to digit 0, so a frame
//   never mixes old and new digits. One digit is shown per REFRESH_DIV-cycle
//   slot, with the anode held off for the first cycle of each slot to avoid
//   ghosting. All outputs are registered.
// Ports:
//   clk         in   1             rising-edge clock
//   rst         in   1             synchronous active-high reset
//   load        in   1             capture value/dp_in/blank_in/lzb into pending
//   value       in   4*NUM_DIGITS  hex nibbles, digit 0 rightmost
//   dp_in       in   NUM_DIGITS    decimal point per digit, 1 = lit
//   blank_in    in   NUM_DIGITS    1 = digit fully dark (dp included)
//   lzb         in   1             leading-zero blanking enable
//   seg         out  8             {dp,g,f,e,d,c,b,a}, polarity per ACTIVE_LOW_SEG
//   an          out  NUM_DIGITS    one-hot digit select, polarity per ACTIVE_LOW_AN
//   frame_done  out  1             pulse when the scan wraps to digit 0
//   load_ack    out  1             pulse when pending data moves into the shadow
// -----------------------------------------------------------------------------
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit ACTIVE_LOW_SEG = 1'b0,
    parameter bit ACTIVE_LOW_AN  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lzb,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done,
    output logic                    load_ack
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [7:0]            SEG_INV  = ACTIVE_LOW_SEG ? 8'hFF : 8'h00;
    localparam logic [NUM_DIGITS-1:0] AN_INV   = ACTIVE_LOW_AN ? {NUM_DIGITS{1'b1}}
                                                               : {NUM_DIGITS{1'b0}};

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic                    pend_lzb_q, pend_lzb_d;
    logic                    pend_vld_q, pend_vld_d;

    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
    logic                    shadow_lzb_q, shadow_lzb_d;

    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_done_q, frame_done_d;
    logic                    load_ack_q, load_ack_d;

    logic                    slot_end_s;
    logic                    wrap_s;
    logic [NUM_DIGITS-1:0]   lz_mask_s;
    logic [3:0]              nib_s;
    logic                    dp_s;
    logic                    blank_s;
    logic                    lz_s;
    logic [7:0]              seg_raw_s;
    logic [NUM_DIGITS-1:0]   an_raw_s;

    sevenseg_lzb_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lzb_mask (
        .value_i   (shadow_val_q),
        .lz_mask_o (lz_mask_s)
    );

    // Slot counter and digit index; a wrap is the last cycle of the last digit's slot.
    always_comb begin
        slot_end_s = (cnt_q == CNT_LAST);
        wrap_s     = slot_end_s && (idx_q == IDX_LAST);
        if (slot_end_s) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end
    end

    // Double buffer: a load always lands in pending; pending reaches the shadow only on a wrap.
    always_comb begin
        pend_val_d     = pend_val_q;
        pend_dp_d      = pend_dp_q;
        pend_blank_d   = pend_blank_q;
        pend_lzb_d     = pend_lzb_q;
        pend_vld_d     = pend_vld_q;
        shadow_val_d   = shadow_val_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_blank_d = shadow_blank_q;
        shadow_lzb_d   = shadow_lzb_q;

        if (wrap_s && pend_vld_q) begin
            shadow_val_d   = pend_val_q;
            shadow_dp_d    = pend_dp_q;
            shadow_blank_d = pend_blank_q;
            shadow_lzb_d   = pend_lzb_q;
        end else begin
            shadow_val_d   = shadow_val_q;
        end

        // A load on the wrap cycle re-arms pending after the old contents were consumed.
        if (load) begin
            pend_val_d   = value;
            pend_dp_d    = dp_in;
            pend_blank_d = blank_in;
            pend_lzb_d   = lzb;
            pend_vld_d   = 1'b1;
        end else if (wrap_s) begin
            pend_vld_d   = 1'b0;
        end else begin
            pend_vld_d   = pend_vld_q;
        end

        frame_done_d = wrap_s;
        load_ack_d   = wrap_s & pend_vld_q;
    end

    // Select the shadow fields of the digit currently being scanned.
    always_comb begin
        nib_s   = 4'h0;
        dp_s    = 1'b0;
        blank_s = 1'b0;
        lz_s    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_s   = shadow_val_q[4*i +: 4];
                dp_s    = shadow_dp_q[i];
                blank_s = shadow_blank_q[i];
                lz_s    = lz_mask_s[i];
            end else begin
                nib_s   = nib_s;
            end
        end
    end

    // Segment and anode patterns; lzb hides the glyph but keeps the dp, blank hides both.
    always_comb begin
        seg_raw_s = SEG_OFF;
        if (blank_s) begin
            seg_raw_s = SEG_OFF;
        end else if (shadow_lzb_q && lz_s) begin
            seg_raw_s[SEG_DP] = dp_s;
        end else begin
            seg_raw_s[SEG_G:SEG_A] = hex_to_seg(nib_s);
            seg_raw_s[SEG_DP]      = dp_s;
        end

        // First cycle of each slot is dead time with no digit selected.
        an_raw_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_raw_s[i] = (cnt_q != '0) && (idx_q == IDX_W'(i));
        end

        seg_d = seg_raw_s ^ SEG_INV;
        an_d  = an_raw_s ^ AN_INV;
    end

    // State and output registers with synchronous reset to the dark display.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            pend_val_q     <= '0;
            pend_dp_q      <= '0;
            pend_blank_q   <= '0;
            pend_lzb_q     <= 1'b0;
            pend_vld_q     <= 1'b0;
            shadow_val_q   <= '0;
            shadow_dp_q    <= '0;
            shadow_blank_q <= '0;
            shadow_lzb_q   <= 1'b0;
            seg_q          <= SEG_OFF ^ SEG_INV;
            an_q           <= AN_INV;
            frame_done_q   <= 1'b0;
            load_ack_q     <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            pend_val_q     <= pend_val_d;
            pend_dp_q      <= pend_dp_d;
            pend_blank_q   <= pend_blank_d;
            pend_lzb_q     <= pend_lzb_d;
            pend_vld_q     <= pend_vld_d;
            shadow_val_q   <= shadow_val_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blank_q <= shadow_blank_d;
            shadow_lzb_q   <= shadow_lzb_d;
            seg_q          <= seg_d;
            an_q           <= an_d;
            frame_done_q   <= frame_done_d;
            load_ack_q     <= load_ack_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
    assign load_ack   = load_ack_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sevenseg_scan_driver
//   Drives two instances (active-high and fully active-low) from the same
//   stimulus and compares every cycle against a reference model that derives
//   the scan position from the number of clock edges since reset and keeps the
//   pending/shadow contents as plain variables.
// -----------------------------------------------------------------------------
module tb_sevenseg_scan_driver;

    localparam int N     = 4;
    localparam int RD    = 4;
    localparam int FRAME = N * RD;

    localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [15:0]   value;
    logic [3:0]    dp_in;
    logic [3:0]    blank_in;
    logic          lzb;

    logic [7:0]    seg_h, seg_l;
    logic [3:0]    an_h, an_l;
    logic          fd_h, fd_l;
    logic          ack_h, ack_l;

    int            n_vec = 0;
    int            n_err = 0;

    // reference model state
    int            e;
    logic [15:0]   sh_val, pe_val;
    logic [3:0]    sh_dp, sh_bl, pe_dp, pe_bl;
    logic          sh_lz, pe_lz, pv;
    logic [7:0]    exp_seg, exp_seg_n;
    logic [3:0]    exp_an, exp_an_n;
    logic          exp_fd, exp_ack;

    always #5 clk = ~clk;

    sevenseg_scan_driver #(
        .NUM_DIGITS (N), .REFRESH_DIV (RD), .ACTIVE_LOW_SEG (1'b0), .ACTIVE_LOW_AN (1'b0)
    ) dut (
        .clk (clk), .rst (rst), .load (load), .value (value), .dp_in (dp_in),
        .blank_in (blank_in), .lzb (lzb), .seg (seg_h), .an (an_h),
        .frame_done (fd_h), .load_ack (ack_h)
    );

    sevenseg_scan_driver #(
        .NUM_DIGITS (N), .REFRESH_DIV (RD), .ACTIVE_LOW_SEG (1'b1), .ACTIVE_LOW_AN (1'b1)
    ) dut_n (
        .clk (clk), .rst (rst), .load (load), .value (value), .dp_in (dp_in),
        .blank_in (blank_in), .lzb (lzb), .seg (seg_l), .an (an_l),
        .frame_done (fd_l), .load_ack (ack_l)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, e, $time);
        end
    endtask

    // Model of one rising edge, using the inputs present at that edge.
    task automatic model_edge(input logic r, input logic ld);
        int c, d;
        logic wrap, lead;
        logic [15:0] upper;
        if (r) begin
            e = 0;
            sh_val = '0; sh_dp = '0; sh_bl = '0; sh_lz = 1'b0;
            pe_val = '0; pe_dp = '0; pe_bl = '0; pe_lz = 1'b0; pv = 1'b0;
            exp_seg = 8'h00; exp_an = 4'h0; exp_fd = 1'b0; exp_ack = 1'b0;
        end else begin
            e = e + 1;
            c = (e - 1) % RD;
            d = ((e - 1) / RD) % N;
            exp_an = (c == 0) ? 4'h0 : 4'(1 << d);
            upper  = sh_val >> (4 * d);
            lead   = sh_lz && (d != 0) && (upper == 16'h0);
            if (sh_bl[d])  exp_seg = 8'h00;
            else if (lead) exp_seg = {sh_dp[d], 7'h00};
            else           exp_seg = {sh_dp[d], DEC[upper[3:0]]};
            wrap    = (e % FRAME) == 0;
            exp_fd  = wrap;
            exp_ack = wrap && pv;
            if (wrap && pv) begin
                sh_val = pe_val; sh_dp = pe_dp; sh_bl = pe_bl; sh_lz = pe_lz; pv = 1'b0;
            end
            if (ld) begin
                pe_val = value; pe_dp = dp_in; pe_bl = blank_in; pe_lz = lzb; pv = 1'b1;
            end
        end
        exp_seg_n = ~exp_seg;
        exp_an_n  = ~exp_an;
    endtask

    task automatic cycle(input logic r, input logic ld, input logic [15:0] v,
                         input logic [3:0] dp, input logic [3:0] bl, input logic lz);
        rst = r; load = ld; value = v; dp_in = dp; blank_in = bl; lzb = lz;
        @(posedge clk);
        model_edge(r, ld);
        @(negedge clk);
        check_eq("seg",        {24'h0, seg_h}, {24'h0, exp_seg});
        check_eq("an",         {28'h0, an_h},  {28'h0, exp_an});
        check_eq("frame_done", {31'h0, fd_h},  {31'h0, exp_fd});
        check_eq("load_ack",   {31'h0, ack_h}, {31'h0, exp_ack});
        check_eq("seg_n",      {24'h0, seg_l}, {24'h0, exp_seg_n});
        check_eq("an_n",       {28'h0, an_l},  {28'h0, exp_an_n});
        check_eq("frame_done_n", {31'h0, fd_l},  {31'h0, exp_fd});
        check_eq("load_ack_n",   {31'h0, ack_l}, {31'h0, exp_ack});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, value, dp_in, blank_in, lzb);
    endtask

    task automatic load_at_wrap(input logic [15:0] v, input logic [3:0] dp,
                                input logic [3:0] bl, input logic lz);
        while (((e + 1) % FRAME) != 0) idle(1);
        cycle(1'b0, 1'b1, v, dp, bl, lz);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_in = '0; lzb = 1'b0;
        e = 0; pv = 1'b0;
        @(negedge clk);

        // reset, then a plain load shown from the following frame
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 1'b0);
        cycle(1'b0, 1'b1, 16'h12AF, 4'h0, 4'h0, 1'b0);
        idle(2 * FRAME + 3);

        // leading-zero blanking, including the all-zero value
        cycle(1'b0, 1'b1, 16'h0040, 4'h0, 4'h0, 1'b1);
        idle(2 * FRAME);
        cycle(1'b0, 1'b1, 16'h0000, 4'h0, 4'h0, 1'b1);
        idle(2 * FRAME);

        // two loads in one frame collapse to one ack; latest wins
        cycle(1'b0, 1'b1, 16'h1111, 4'h0, 4'h0, 1'b0);
        idle(3);
        cycle(1'b0, 1'b1, 16'h2222, 4'h0, 4'h0, 1'b0);
        idle(2 * FRAME);

        // load on the wrap cycle waits a full frame
        load_at_wrap(16'h3456, 4'h0, 4'h0, 1'b0);
        idle(2 * FRAME + 2);

        // forced blank and decimal point
        cycle(1'b0, 1'b1, 16'h8888, 4'b0001, 4'b0100, 1'b0);
        idle(2 * FRAME);

        // lzb-blanked digit keeps its decimal point
        cycle(1'b0, 1'b1, 16'h0007, 4'b1000, 4'h0, 1'b1);
        idle(2 * FRAME);

        // reset mid-slot discards a pending load
        idle(5);
        cycle(1'b0, 1'b1, 16'hABCD, 4'hF, 4'h0, 1'b0);
        cycle(1'b1, 1'b0, 16'hABCD, 4'hF, 4'h0, 1'b0);
        idle(2 * FRAME + 4);

        // randomized traffic with occasional resets
        for (int k = 0; k < 1500; k++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) == 0),
                  16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
                  1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
